// File: rtl/shift_pkg.sv
// Shared constants for the serial shifter: data width, op codes, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/shift_step.sv
// One-bit shift of a word for the given op; sign fill exists only with SHIFT_SRA_EN.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
import shift_pkg::*;

module shift_step (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic fill;

`ifdef SHIFT_SRA_EN
  assign fill = (op == OP_SRA) ? din[DATA_W-1] : 1'b0;
`else
  assign fill = 1'b0;
`endif

  // Anything that is not SLL (including the reserved code) shifts right.
  assign dout = (op == OP_SLL) ? {din[DATA_W-2:0], 1'b0}
                               : {fill, din[DATA_W-1:1]};
endmodule

// File: rtl/serial_shifter.sv
// Serial 32-bit SRL/SLL/SRA, one bit per cycle; SRA sign fill only with SHIFT_SRA_EN.
// Latency: accept at edge k, out_valid after edge k+1+min(Y,32).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
import shift_pkg::*;

module serial_shifter (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Z,
  output logic              busy
);
  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] step_out;

  shift_step u_step (
    .op   (op_q),
    .din  (shreg),
    .dout (step_out)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
  assign Z         = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= OP_SRL;
      count <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg <= X;
            op_q  <= op;
            // Any amount of 32 or more saturates; 32 steps already clear/sign-fill every bit.
            count <= (|Y[DATA_W-1:5]) ? CNT_W'(32) : Y[CNT_W-1:0];
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (count == '0) begin
            state <= ST_DONE;
          end else begin
            shreg <= step_out;
            count <= count - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter; SRA expectations follow SHIFT_SRA_EN.
module tb_serial_shifter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_SRA_EN
  localparam logic [31:0] SRA4_EXP  = 32'hF8A1BC97;
  localparam logic [31:0] SRA40_EXP = 32'hFFFFFFFF;
`else
  localparam logic [31:0] SRA4_EXP  = 32'h08A1BC97;
  localparam logic [31:0] SRA40_EXP = 32'h00000000;
`endif

  serial_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, then counts edges until out_valid (lat = -1 on timeout).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                        output logic [31:0] z, output int lat);
    X = x;
    Y = y;
    op = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    X = 32'hDEADBEEF;
    Y = 32'd3;
    op = 2'b01;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    z = Z;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    X = '0;
    Y = '0;
    op = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (Z !== 32'h0) begin
      errors++;
      $display("FAIL reset_z: got %h required 00000000", Z);
    end
  endtask

  task automatic test_srl();
    logic [31:0] z;
    int lat;
    out_ready = 1'b1;
    run_op(32'h8A1BC97A, 32'd4, 2'b00, z, lat);
    checks++;
    if (z !== 32'h08A1BC97) begin
      errors++;
      $display("FAIL srl4_value: got %h required 08A1BC97", z);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL srl4_latency: got %0d required 5", lat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL srl4_single_cycle: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    checks++;
    if (Z !== 32'h08A1BC97) begin
      errors++;
      $display("FAIL srl4_z_kept_idle: got %h required 08A1BC97", Z);
    end
  endtask

  task automatic test_sra();
    logic [31:0] z;
    int lat;
    out_ready = 1'b1;
    run_op(32'h8A1BC97A, 32'd4, 2'b10, z, lat);
    checks++;
    if (z !== SRA4_EXP || lat !== 5) begin
      errors++;
      $display("FAIL sra4: got %h lat %0d required %h lat 5", z, lat, SRA4_EXP);
    end
    tick();
    run_op(32'hF0000000, 32'd4, 2'b11, z, lat);
    checks++;
    if (z !== 32'h0F000000 || lat !== 5) begin
      errors++;
      $display("FAIL op11_as_srl: got %h lat %0d required 0F000000 lat 5", z, lat);
    end
    tick();
  endtask

  task automatic test_sll();
    logic [31:0] z;
    int lat;
    out_ready = 1'b1;
    run_op(32'h8A1BC97A, 32'd8, 2'b01, z, lat);
    checks++;
    if (z !== 32'h1BC97A00 || lat !== 9) begin
      errors++;
      $display("FAIL sll8: got %h lat %0d required 1BC97A00 lat 9", z, lat);
    end
    tick();
    run_op(32'h8A1BC97A, 32'd0, 2'b01, z, lat);
    checks++;
    if (z !== 32'h8A1BC97A || lat !== 1) begin
      errors++;
      $display("FAIL y0: got %h lat %0d required 8A1BC97A lat 1", z, lat);
    end
    tick();
  endtask

  task automatic test_large();
    logic [31:0] z;
    int lat;
    out_ready = 1'b1;
    run_op(32'h8A1BC97A, 32'd40, 2'b00, z, lat);
    checks++;
    if (z !== 32'h0 || lat !== 33) begin
      errors++;
      $display("FAIL srl40: got %h lat %0d required 00000000 lat 33", z, lat);
    end
    tick();
    run_op(32'h8A1BC97A, 32'd40, 2'b10, z, lat);
    checks++;
    if (z !== SRA40_EXP || lat !== 33) begin
      errors++;
      $display("FAIL sra40: got %h lat %0d required %h lat 33", z, lat, SRA40_EXP);
    end
    tick();
    run_op(32'h0000FFFF, 32'h80000001, 2'b01, z, lat);
    checks++;
    if (z !== 32'h0 || lat !== 33) begin
      errors++;
      $display("FAIL sll_huge: got %h lat %0d required 00000000 lat 33", z, lat);
    end
    tick();
    run_op(32'h80000001, 32'd31, 2'b00, z, lat);
    checks++;
    if (z !== 32'h1 || lat !== 32) begin
      errors++;
      $display("FAIL srl31: got %h lat %0d required 00000001 lat 32", z, lat);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] z;
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(32'h00001234, 32'd2, 2'b01, z, lat);
    checks++;
    if (z !== 32'h000048D0 || lat !== 3) begin
      errors++;
      $display("FAIL hold_value: got %h lat %0d required 000048D0 lat 3", z, lat);
    end
    X = 32'h55555555;
    Y = 32'd1;
    op = 2'b00;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || Z !== 32'h000048D0 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: %0d bad cycles, required 0", bad);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Z !== 32'h000048D0) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b Z=%h required 0 1 0 000048D0",
               out_valid, in_ready, busy, Z);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int lat;
    int seen;
    out_ready = 1'b1;
    X = 32'hCAFEF00D;
    Y = 32'd20;
    op = 2'b00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_busy: busy=%b out_valid=%b required 1 0", busy, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || Z !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_state: in_ready=%b busy=%b out_valid=%b Z=%h required 1 0 0 00000000",
               in_ready, busy, out_valid, Z);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_valid: %0d out_valid cycles, required 0", seen);
    end
    run_op(32'h0F0F0F0F, 32'd4, 2'b01, z, lat);
    checks++;
    if (z !== 32'hF0F0F0F0 || lat !== 5) begin
      errors++;
      $display("FAIL after_reset_op: got %h lat %0d required F0F0F0F0 lat 5", z, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra();
    test_sll();
    test_large();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: operand set X/Y/op is valid.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: block can accept an operand set.
REQ-005 The block SHALL have the port X, input, 32 bits: value to be shifted.
REQ-006 The block SHALL have the port Y, input, 32 bits: shift amount, full 32-bit unsigned.
REQ-007 The block SHALL have the port op, input, 2 bits: 00 SRL, 01 SLL, 10 SRA, 11 reserved.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: Z holds a completed result.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have the port Z, output, 32 bits: shift result.
REQ-011 The block SHALL have the port busy, output, 1 bit: high in SHIFT or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, decoded combinationally from state.
REQ-014 Accept SHALL occur when in_valid && in_ready at a rising edge: latch X into the shift register, latch op, load count = (Y >= 32) ? 32 : Y[5:0], go to SHIFT.
REQ-015 In SHIFT, count == 0 SHALL move the FSM to DONE; otherwise perform one 1-bit shift per cycle and decrement count.
REQ-016 The 1-bit shift SHALL be: SRL fills bit 31 with 0; SLL fills bit 0 with 0; SRA fills bit 31 with the current bit 31.
REQ-017 Latency SHALL be exact: for an accept at edge k with effective amount N = min(Y,32), out_valid rises after edge k+1+N (Y=0 gives 1 cycle in SHIFT).
REQ-018 Results SHALL match Verilog 32-bit X>>Y, X<<Y and $signed(X)>>>Y, including Y >= 32: SRL/SLL give 0, SRA gives 32 copies of X[31].
REQ-019 DONE SHALL hold out_valid=1 and Z stable until out_ready=1 at an edge, then return to IDLE; there is no accept in that same edge.
REQ-020 Z SHALL equal the shift register and keep the last result in IDLE until the next accept.
REQ-021 op=11 SHALL be executed as SRL.
REQ-022 in_valid, X, Y and op SHALL be ignored outside IDLE; X, Y and op are sampled only at the accept edge.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, Z=0, count=0 and latched op=SRL, so out_valid=0, busy=0 and in_ready=1 from the next cycle.
REQ-024 rst SHALL take priority over accept, shift and out_ready handshake in every state; a reset during SHIFT or DONE discards the operation with no out_valid pulse.

Configuration
REQ-025 With macro SHIFT_SRA_EN defined, op=10 SHALL perform arithmetic right shift per REQ-016/REQ-018.
REQ-026 Without SHIFT_SRA_EN, op=10 SHALL be executed as SRL and no sign-fill logic SHALL be synthesized.

Structure
REQ-027 A shared package shift_pkg SHALL hold: DATA_W=32, the op codes OP_SRL/OP_SLL/OP_SRA, and the FSM state encoding.
REQ-028 A combinational sub-module shift_step SHALL implement the 1-bit shift for a given op; serial_shifter instantiates it once.

Verification
REQ-029 The bench SHALL cover: X=32'h8A1BC97A, Y=4, op=SRL, out_ready=1 -> Z=32'h08A1BC97, out_valid after edge k+5, a single cycle high.
REQ-030 The bench SHALL cover: the same X, Y=4, op=SRA with SHIFT_SRA_EN -> Z=32'hF8A1BC97; without the macro -> Z=32'h08A1BC97.
REQ-031 The bench SHALL cover: X=32'h8A1BC97A, Y=8, op=SLL -> Z=32'h1BC97A00; X, Y=0 -> Z=X and out_valid after edge k+1.
REQ-032 The bench SHALL cover: Y=40 with op=SRL -> Z=0, and with op=SRA -> Z=32'hFFFFFFFF, latency 33 cycles in SHIFT.
REQ-033 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> Z and out_valid stable, in_ready=0, a new in_valid ignored; release -> IDLE next cycle.
REQ-034 The bench SHALL cover: rst pulsed 1 cycle mid-SHIFT (Y=20, after 5 cycles) -> IDLE, Z=0, no out_valid; the next operation completes correctly.
